// File: rtl/note_div_arbiter_if.sv
// note_div_arbiter_if: requester-side and result-side handshake bundle of the note divider arbiter
interface note_div_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [6*NUM_REQ-1:0] req_note;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDW-1:0]       out_id;
    logic [2:0]           out_octave;
    logic [3:0]           out_semitone;
    logic                 out_error;

    modport slave (
        input  req_valid, req_note, out_ready,
        output req_ready, out_valid, out_id, out_octave, out_semitone, out_error
    );

    modport master (
        output req_valid, req_note, out_ready,
        input  req_ready, out_valid, out_id, out_octave, out_semitone, out_error
    );
endinterface

// File: rtl/note_div_arbiter.sv
// note_div_arbiter: round-robin sharing of one combinational divide-by-12 among note requesters
module note_div_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NOTE_MAX = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    note_div_arbiter_if.slave        bus,
    output logic [5:0]               div_numer,
    input  logic [2:0]               div_quotient,
    input  logic [3:0]               div_remain,
    output logic                     busy
);
    localparam int IDW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, DIVIDE, OUTPUT} state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr, id_q, win;
    logic [5:0]     note_q;
    logic [2:0]     octave_q;
    logic [3:0]     semitone_q;
    logic           error_q, found;

    // scan downward so the lowest offset from ptr is the last (winning) assignment
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? DIVIDE : IDLE;
            DIVIDE:  state_n = OUTPUT;
            OUTPUT:  state_n = bus.out_ready ? IDLE : OUTPUT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            id_q       <= '0;
            note_q     <= '0;
            octave_q   <= '0;
            semitone_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && found) begin
                note_q <= bus.req_note[int'(win)*6 +: 6];
                id_q   <= win;
            end
            if (state == DIVIDE) begin
                octave_q   <= (note_q > 6'(NOTE_MAX)) ? 3'd0 : div_quotient;
                semitone_q <= (note_q > 6'(NOTE_MAX)) ? 4'd0 : div_remain;
                error_q    <= note_q > 6'(NOTE_MAX);
            end
            if (state == OUTPUT && bus.out_ready)
                ptr <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        end
    end

    // grant is gated by rst_n so it also drops immediately on reset assertion
    assign bus.req_ready    = (rst_n && state == IDLE && found) ? NUM_REQ'(1) << win : '0;
    assign bus.out_valid    = state == OUTPUT;
    assign bus.out_id       = id_q;
    assign bus.out_octave   = octave_q;
    assign bus.out_semitone = semitone_q;
    assign bus.out_error    = error_q;
    assign div_numer        = note_q;
    assign busy             = state != IDLE;
endmodule

// File: tb/tb_note_div_arbiter.sv
// tb_note_div_arbiter: randomized and directed checks of note_div_arbiter against a transaction-level model
module tb_note_div_arbiter;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] div_numer;
    logic [2:0] div_quotient;
    logic [3:0] div_remain;
    logic       busy;

    always #5 clk = ~clk;

    note_div_arbiter_if #(.NUM_REQ(N)) bus();

    note_div_arbiter #(.NUM_REQ(N), .NOTE_MAX(19)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .div_numer(div_numer),
        .div_quotient(div_quotient),
        .div_remain(div_remain),
        .busy(busy)
    );

    // the shared divider itself
    assign div_quotient = 3'(div_numer / 6'd12);
    assign div_remain   = 4'(div_numer % 6'd12);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: which slot a transaction is in (0 waiting, 1 dividing, 2 presenting)
    int m_phase = 0, m_ptr = 0, m_id = 0, m_note = 0;

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        int w;
        logic [N-1:0] er;
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_id = 0; m_note = 0;
        end
        w  = winner(bus.req_valid, m_ptr);
        er = (rst_n && m_phase == 0 && w >= 0) ? N'(1) << w : '0;
        chk("m_req_ready", int'(bus.req_ready), int'(er));
        chk("m_busy", int'(busy), int'(m_phase != 0));
        chk("m_out_valid", int'(bus.out_valid), int'(m_phase == 2));
        chk("m_div_numer", int'(div_numer), m_note);
        if (m_phase == 2) begin
            chk("m_out_id", int'(bus.out_id), m_id);
            chk("m_out_octave", int'(bus.out_octave), m_note > 19 ? 0 : m_note / 12);
            chk("m_out_semitone", int'(bus.out_semitone), m_note > 19 ? 0 : m_note % 12);
            chk("m_out_error", int'(bus.out_error), int'(m_note > 19));
        end
        if (rst_n) begin
            if (m_phase == 0 && w >= 0) begin
                m_note  = int'(bus.req_note[6*w +: 6]);
                m_id    = w;
                m_phase = 1;
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (m_phase == 2 && bus.out_ready) begin
                m_phase = 0;
                m_ptr   = (m_id + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    int grants[$];
    int ids[$];
    int gexp[6] = '{0, 1, 2, 3, 0, 1};
    int n4[4]   = '{0, 19, 20, 63};
    int o4[4]   = '{0, 1, 0, 0};
    int s4[4]   = '{0, 7, 0, 0};
    int e4[4]   = '{0, 0, 1, 1};

    initial begin
        bus.req_valid = '0;
        bus.req_note  = '0;
        bus.out_ready = 1'b1;
        tick(); tick();
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_id", int'(bus.out_id), 0);
        chk("rst_out_octave", int'(bus.out_octave), 0);
        chk("rst_out_semitone", int'(bus.out_semitone), 0);
        chk("rst_out_error", int'(bus.out_error), 0);
        chk("rst_div_numer", int'(div_numer), 0);
        rst_n = 1'b1;
        tick();

        // single requester 2, note 17
        bus.req_valid = 4'b0100;
        bus.req_note[17:12] = 6'd17;
        #1;
        chk("t1_ready", int'(bus.req_ready), 4);
        tick();
        bus.req_valid = '0;
        chk("t1_busy_div", int'(busy), 1);
        chk("t1_valid_div", int'(bus.out_valid), 0);
        tick();
        chk("t1_valid", int'(bus.out_valid), 1);
        chk("t1_id", int'(bus.out_id), 2);
        chk("t1_octave", int'(bus.out_octave), 1);
        chk("t1_semitone", int'(bus.out_semitone), 5);
        chk("t1_error", int'(bus.out_error), 0);
        tick();
        chk("t1_busy_end", int'(busy), 0);

        // all requesters continuously valid, from ptr 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 18; c++) begin
            bus.req_note = 24'($urandom);
            #1;
            if (bus.req_ready != 0) grants.push_back(onehot_idx(bus.req_ready));
            if (bus.out_valid && bus.out_ready) ids.push_back(int'(bus.out_id));
            tick();
        end
        bus.req_valid = '0;
        chk("t2_grant_count", grants.size(), 6);
        chk("t2_id_count", ids.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("t2_grant_order", grants.size() > i ? grants[i] : -1, gexp[i]);
            chk("t2_id_order", ids.size() > i ? ids[i] : -1, gexp[i]);
        end
        repeat (4) tick();

        // backpressure holds the result; req 3 waits
        bus.req_valid = 4'b0010;
        bus.req_note[11:6] = 6'd9;
        bus.out_ready = 1'b0;
        #1;
        chk("t3_ready1", int'(bus.req_ready), 2);
        tick();
        bus.req_valid = 4'b1000;
        bus.req_note[23:18] = 6'd5;
        tick();
        for (int c = 0; c < 6; c++) begin
            chk("t3_valid", int'(bus.out_valid), 1);
            chk("t3_id", int'(bus.out_id), 1);
            chk("t3_octave", int'(bus.out_octave), 0);
            chk("t3_semitone", int'(bus.out_semitone), 9);
            chk("t3_ready_hold", int'(bus.req_ready), 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("t3_ready3", int'(bus.req_ready), 8);
        tick();
        bus.req_valid = '0;
        repeat (3) tick();

        // boundary notes on requester 0
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 4'b0001;
            bus.req_note[5:0] = 6'(n4[i]);
            tick();
            bus.req_valid = '0;
            tick();
            chk("t4_valid", int'(bus.out_valid), 1);
            chk("t4_octave", int'(bus.out_octave), o4[i]);
            chk("t4_semitone", int'(bus.out_semitone), s4[i]);
            chk("t4_error", int'(bus.out_error), e4[i]);
            tick();
        end

        // asynchronous reset during DIVIDE
        bus.req_valid = 4'b0001;
        bus.req_note[5:0] = 6'd5;
        tick();
        bus.req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_valid", int'(bus.out_valid), 0);
        chk("t5_numer", int'(div_numer), 0);
        chk("t5_octave", int'(bus.out_octave), 0);
        chk("t5_semitone", int'(bus.out_semitone), 0);
        chk("t5_error", int'(bus.out_error), 0);
        chk("t5_id", int'(bus.out_id), 0);
        tick();
        bus.req_valid = 4'b1010;
        #1;
        chk("t5_ready_in_rst", int'(bus.req_ready), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_first_grant", int'(bus.req_ready), 2);
        tick();

        // randomized traffic with backpressure
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = N'($urandom_range(0, 15));
            bus.req_note  = 24'($urandom);
            bus.out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/note_div_arbiter.md
# note_div_arbiter

Round-robin scheduler that shares the single combinational note divider (6-bit note index → octave quotient and semitone remainder, divide by 12) among several voice requesters in the synth. Each requester hands over a note through a valid/ready handshake. The block drives the shared divider for one full cycle, registers its result, and presents it to the downstream tone-generator loader tagged with the requester ID. Notes outside the divider's valid range are flagged as errors and never reach the divider.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- NOTE_MAX, 19, highest note index the shared divider supports

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- req_valid  input  NUM_REQ  bit i: requester i offers a note
- req_note  input  6*NUM_REQ  requester i note in bits [6i+5:6i]
- req_ready  output  NUM_REQ  one-hot grant/accept, combinational in IDLE
- div_numer  output  6  operand to shared divider
- div_quotient  input  3  divider quotient (octave)
- div_remain  input  4  divider remainder (semitone, 0..11)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_id  output  max(1,$clog2(NUM_REQ))  requester that owns the result
- out_octave  output  3  registered quotient
- out_semitone  output  4  registered remainder
- out_error  output  1  note > NOTE_MAX; octave/semitone forced to 0
- busy  output  1  state ≠ IDLE

## Operation

- FSM states: IDLE, DIVIDE, OUTPUT.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from ptr upward with wrap.
  - req_ready[winner]=1. All other req_ready bits are 0, and all are 0 if there is no request.
  - On the edge, latch note_q ← req_note[winner] and id_q ← winner, then go to DIVIDE.
  - Arbitration is re-evaluated every IDLE cycle. A requester may drop req_valid before it is granted.
- DIVIDE:
  - div_numer = note_q for the whole cycle.
  - On the edge, register the result:
    - If note_q ≤ NOTE_MAX: out_octave ← div_quotient, out_semitone ← div_remain, out_error ← 0.
    - Otherwise: out_octave ← 0, out_semitone ← 0, out_error ← 1.
  - Then go to OUTPUT.
- OUTPUT:
  - out_valid=1.
  - out_id, out_octave, out_semitone and out_error are held stable until the transfer (out_valid & out_ready) completes.
  - On the transfer edge: go to IDLE and set ptr ← (id_q+1) mod NUM_REQ.
- ptr changes only on a completed output transfer. This gives strict round-robin fairness.
- div_numer outside DIVIDE holds the last note_q; the divider output is ignored there.
- req_ready is never asserted outside IDLE. Requests arriving while busy wait.

## Timing

- Reset value of every output and register:
  - req_ready, out_valid, out_error, busy = 0
  - out_id, out_octave, out_semitone, div_numer, note_q = 0
  - ptr = 0, state = IDLE
- Latency: handshake at edge k (IDLE) → out_valid high from edge k+2.
- Throughput: one result per 3 cycles when out_ready is held high. IDLE may accept on the cycle immediately after the OUTPUT transfer.
- The divider path is combinational for one full cycle: div_numer → div_quotient/div_remain → registers.
- Backpressure: out_ready low holds OUTPUT indefinitely. No new grant is made; all outputs stay stable.
- Simultaneous requests are resolved by ptr only. A requester that keeps req_valid high is granted at most once per NUM_REQ transfers while others are also requesting.
- Boundary notes:
  - Note 0 → octave 0, semitone 0.
  - Note NOTE_MAX=19 → octave 1, semitone 7.
  - Note 20..63 → error path.
- Reset asserted in any state:
  - Outputs go to reset values immediately (asynchronously).
  - In-flight result is discarded; ptr returns to 0.
  - After release, the first grant goes to the lowest-index valid requester.

## Test plan

1. Only req 2 valid, note 17, out_ready=1 → req_ready=0100 at cycle 0. From edge 2: out_valid=1, out_id=2, out_octave=1, out_semitone=5, out_error=0. busy low from edge 3.
2. All four requesters continuously valid, out_ready=1 → grant order 0,1,2,3,0,1. One out_valid per 3 cycles; out_id follows the same order.
3. Req 1 note 9, out_ready=0 for 6 cycles then 1 → out_valid and out_id=1/octave 0/semitone 9 stable all 6 cycles. req_ready stays 0 for req 3 valid during that time; req 3 is granted the cycle after the transfer.
4. Notes 0, 19, 20, 63 on req 0 in sequence → (0,0,err0), (1,7,err0), (0,0,err1), (0,0,err1).
5. rst_n pulled low mid-cycle during DIVIDE → all outputs 0 before the next clk edge. After release, with req 3 and req 1 valid, req 1 is granted first (ptr=0).
